// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: read FSM states,
// the word-offset constant and the byte-lane merge used by forwarding.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rd_state_t;

  localparam int WORD_LSB = 2;

  // Lane i of the result comes from data when lanes[i] is set, else from word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_write_buffer.sv
// One-entry posted store buffer. It drains whenever the array port is free
// (any cycle that is not a load response) and refills on the same edge.
module dmem_write_buffer
  import dmem_pkg::*;
#(
  parameter int INDEX_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               resp_active,
  input  logic               wr_valid,
  input  logic [31:0]        wr_address,
  input  logic [3:0]         wr_byte,
  input  logic [31:0]        wr_data,
  output logic               wr_ready,
  output logic               drain_en,
  output logic               buf_valid,
  output logic [INDEX_W-1:0] buf_index,
  output logic [3:0]         buf_byte,
  output logic [31:0]        buf_data
);

  logic               buf_valid_reg;
  logic [INDEX_W-1:0] buf_index_reg;
  logic [3:0]         buf_byte_reg;
  logic [31:0]        buf_data_reg;
  logic               accept;
  logic               unused_wr_address_bits;

  assign unused_wr_address_bits = ^{wr_address[31:INDEX_W+WORD_LSB], wr_address[WORD_LSB-1:0]};

  assign drain_en = buf_valid_reg && !resp_active;
  assign wr_ready = !buf_valid_reg || !resp_active;
  assign accept   = wr_valid && wr_ready;

  // A new store overwrites the entry at the same edge the old one drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_reg <= 1'b0;
      buf_index_reg <= '0;
      buf_byte_reg  <= '0;
      buf_data_reg  <= '0;
    end else if (accept) begin
      buf_valid_reg <= 1'b1;
      buf_index_reg <= wr_address[INDEX_W+WORD_LSB-1:WORD_LSB];
      buf_byte_reg  <= wr_byte;
      buf_data_reg  <= wr_data;
    end else if (drain_en) begin
      buf_valid_reg <= 1'b0;
    end
  end

  assign buf_valid = buf_valid_reg;
  assign buf_index = buf_index_reg;
  assign buf_byte  = buf_byte_reg;
  assign buf_data  = buf_data_reg;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: posted stores through a one-entry buffer, loads with
// configurable wait states and byte forwarding from the pending store.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_WAIT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_address,
  input  logic [3:0]  wr_byte,
  input  logic [31:0] wr_data,
  input  logic        rd_req,
  output logic        rd_ready,
  input  logic [31:0] rd_address,
  output logic        rd_valid,
  output logic [31:0] rd_data
);

  localparam int INDEX_W = $clog2(DEPTH_WORDS);

  rd_state_t          state_reg, state_next;
  logic [2:0]         count_reg, count_next;
  logic [INDEX_W-1:0] index_reg, index_next;
  logic [INDEX_W-1:0] rd_index, read_index;
  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        ram_q_reg;
  logic               mem_we;
  logic               fwd_hit;
  logic [3:0]         fwd_lanes;
  logic               unused_rd_address_bits;

  logic               buf_valid, drain_en;
  logic [INDEX_W-1:0] buf_index;
  logic [3:0]         buf_byte;
  logic [31:0]        buf_data;

  assign unused_rd_address_bits = ^{rd_address[31:INDEX_W+WORD_LSB], rd_address[WORD_LSB-1:0]};
  assign rd_index = rd_address[INDEX_W+WORD_LSB-1:WORD_LSB];

  dmem_write_buffer #(.INDEX_W(INDEX_W)) u_wbuf (
    .clk        (clk),
    .reset      (reset),
    .resp_active(state_reg == RESP),
    .wr_valid   (wr_valid),
    .wr_address (wr_address),
    .wr_byte    (wr_byte),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .drain_en   (drain_en),
    .buf_valid  (buf_valid),
    .buf_index  (buf_index),
    .buf_byte   (buf_byte),
    .buf_data   (buf_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      index_reg <= index_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    index_next = index_reg;
    case (state_reg)
      IDLE: begin
        if (rd_req) begin
          index_next = rd_index;
          if (READ_WAIT == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = 3'(READ_WAIT);
          end
        end
      end
      WAIT: begin
        count_next = count_reg - 3'd1;
        if (count_reg == 3'd1) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The array word is read on the edge entering RESP; a drain to the same
  // word on that edge is folded in so the registered read is never stale.
  assign read_index = (state_reg == IDLE) ? rd_index : index_reg;
  assign mem_we     = drain_en && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_byte[i]) mem[buf_index][8*i +: 8] <= buf_data[8*i +: 8];
      end
    end
    if (mem_we && buf_index == read_index)
      ram_q_reg <= merge_lanes(mem[read_index], buf_data, buf_byte);
    else
      ram_q_reg <= mem[read_index];
  end

  assign fwd_hit = buf_valid && (buf_index == index_reg);

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign fwd_lanes[gi] = fwd_hit && buf_byte[gi];
  end

  always_comb begin
    rd_ready = 1'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
    case (state_reg)
      IDLE: rd_ready = 1'b1;
      RESP: begin
        rd_valid = 1'b1;
        rd_data  = merge_lanes(ram_q_reg, buf_data, fwd_lanes);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder with READ_WAIT 1, 0 and 7;
// a per-instance memory model and load scoreboard check every cycle.
module tb_dmem_responder;

  localparam int NI = 3;

  typedef struct {
    logic [9:0] idx;
    int         due;
  } ld_t;

  logic        clk;
  logic        reset;
  logic        wr_valid   [NI];
  logic        wr_ready   [NI];
  logic [31:0] wr_address [NI];
  logic [3:0]  wr_byte    [NI];
  logic [31:0] wr_data    [NI];
  logic        rd_req     [NI];
  logic        rd_ready   [NI];
  logic [31:0] rd_address [NI];
  logic        rd_valid   [NI];
  logic [31:0] rd_data    [NI];

  int checks = 0;
  int fails  = 0;
  int pend_cnt [NI];

  function automatic int rw_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] l);
    return {{8{l[3]}}, {8{l[2]}}, {8{l[1]}}, {8{l[0]}}};
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d: got %h, required %h", name, k, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int RW = (gi == 0) ? 1 : ((gi == 1) ? 0 : 7);

    dmem_responder #(.DEPTH_WORDS(1024), .READ_WAIT(RW)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_valid  (wr_valid[gi]),
      .wr_ready  (wr_ready[gi]),
      .wr_address(wr_address[gi]),
      .wr_byte   (wr_byte[gi]),
      .wr_data   (wr_data[gi]),
      .rd_req    (rd_req[gi]),
      .rd_ready  (rd_ready[gi]),
      .rd_address(rd_address[gi]),
      .rd_valid  (rd_valid[gi]),
      .rd_data   (rd_data[gi])
    );

    // Model: memory holds the latest accepted stores; a load sees every store
    // accepted before its response cycle. undo_* lets reset discard the
    // store still sitting in the buffer.
    initial begin : monitor
      ld_t         pend [$];
      logic [31:0] mem   [1024];
      logic [3:0]  known [1024];
      int          cyc;
      bit          buf_full, resp_now, exp_rd_ready;
      logic [9:0]  undo_idx, idx;
      logic [31:0] undo_word, m;
      logic [3:0]  undo_known;
      ld_t         it;
      cyc = 0;
      buf_full = 0;
      undo_idx = '0;
      undo_word = '0;
      undo_known = '0;
      for (int i = 0; i < 1024; i++) begin
        mem[i] = '0;
        known[i] = '0;
      end
      pend_cnt[gi] = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
          if (buf_full) begin
            mem[undo_idx] = undo_word;
            known[undo_idx] = undo_known;
          end
          buf_full = 0;
          pend.delete();
        end else begin
          while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
          resp_now = (pend.size() > 0) && (pend[0].due == cyc);
          exp_rd_ready = (pend.size() == 0);
          chk("rd_valid", gi, 32'(rd_valid[gi]), 32'(resp_now));
          chk("rd_ready", gi, 32'(rd_ready[gi]), 32'(exp_rd_ready));
          chk("wr_ready", gi, 32'(wr_ready[gi]), 32'(!(buf_full && resp_now)));
          if (resp_now) begin
            it = pend.pop_front();
            m = lane_mask(known[it.idx]);
            $display("inst%0d cyc %0d load  idx=%03h data=%h model=%h lanes=%b",
                     gi, cyc, it.idx, rd_data[gi], mem[it.idx], known[it.idx]);
            chk("rd_data", gi, rd_data[gi] & m, mem[it.idx] & m);
          end else begin
            chk("rd_data_idle", gi, rd_data[gi], 32'h0);
          end
          if (rd_req[gi] && rd_ready[gi]) begin
            it.idx = rd_address[gi][11:2];
            it.due = cyc + 1 + RW;
            pend.push_back(it);
          end
          if (wr_valid[gi] && wr_ready[gi]) begin
            idx = wr_address[gi][11:2];
            undo_idx = idx;
            undo_word = mem[idx];
            undo_known = known[idx];
            for (int b = 0; b < 4; b++) begin
              if (wr_byte[gi][b]) begin
                mem[idx][8*b +: 8] = wr_data[gi][8*b +: 8];
                known[idx][b] = 1'b1;
              end
            end
            $display("inst%0d cyc %0d store idx=%03h lanes=%b data=%h",
                     gi, cyc, idx, wr_byte[gi], wr_data[gi]);
            buf_full = 1;
          end else if (!resp_now) begin
            buf_full = 0;
          end
        end
        pend_cnt[gi] = pend.size();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a store and/or a load together and holds each until accepted.
  task automatic issue(input int k, input bit dw, input logic [31:0] wa, input logic [3:0] wb,
                       input logic [31:0] wd, input bit dr, input logic [31:0] ra);
    bit pw, pr;
    int n;
    pw = dw;
    pr = dr;
    n = 0;
    wr_valid[k] = pw;
    wr_address[k] = wa;
    wr_byte[k] = wb;
    wr_data[k] = wd;
    rd_req[k] = pr;
    rd_address[k] = ra;
    while ((pw || pr) && n < 50) begin
      @(negedge clk);
      if (pw && wr_ready[k]) pw = 0;
      if (pr && rd_ready[k]) pr = 0;
      step();
      wr_valid[k] = pw;
      rd_req[k] = pr;
      n++;
    end
    if (pw || pr) begin
      checks++;
      fails++;
      $display("FAIL issue_timeout inst%0d: pending store %0d load %0d, required both accepted", k, pw, pr);
      wr_valid[k] = 0;
      rd_req[k] = 0;
    end
  endtask

  task automatic run_tests(input int k);
    logic [31:0] a, ra, d;
    int op;
    $display("instance %0d READ_WAIT=%0d", k, rw_of(k));
    issue(k, 1, 32'h40, 4'hF, 32'h1122_3344, 0, 0);
    repeat (2) step();
    issue(k, 0, 0, 0, 0, 1, 32'h40);
    repeat (10) step();
    // Same-cycle store and load: response must include the store's lane.
    issue(k, 1, 32'h40, 4'b0100, 32'hAAAA_AAAA, 1, 32'h40);
    repeat (10) step();
    issue(k, 0, 0, 0, 0, 1, 32'h43);
    repeat (10) step();
    issue(k, 1, 32'h80, 4'hF, 32'hCAFE_F00D, 0, 0);
    issue(k, 1, 32'h84, 4'hF, 32'h0102_0304, 0, 0);
    issue(k, 1, 32'h88, 4'b0000, 32'hFFFF_FFFF, 0, 0);
    repeat (2) step();
    // Load then two stores: the second one meets a full buffer in RESP.
    issue(k, 0, 0, 0, 0, 1, 32'h84);
    issue(k, 1, 32'h84, 4'b0011, 32'h5555_6666, 0, 0);
    issue(k, 1, 32'h88, 4'b1001, 32'h7700_0088, 0, 0);
    repeat (10) step();
    issue(k, 0, 0, 0, 0, 1, 32'h84);
    repeat (10) step();
    issue(k, 0, 0, 0, 0, 1, 32'h88);
    repeat (10) step();
    issue(k, 1, 32'h1000, 4'hF, 32'hDEAD_BEEF, 0, 0);
    repeat (2) step();
    issue(k, 0, 0, 0, 0, 1, 32'h0);
    repeat (10) step();
    if (rw_of(k) >= 2) begin
      issue(k, 0, 0, 0, 0, 1, 32'h80);
      issue(k, 1, 32'h80, 4'hF, 32'h0BAD_0BAD, 0, 0);
      reset = 1;
      step();
      reset = 0;
      repeat (12) step();
      issue(k, 0, 0, 0, 0, 1, 32'h80);
      repeat (10) step();
    end
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 4));
      a = $urandom;
      a[11:6] = 6'd0;
      ra = $urandom;
      ra[11:6] = 6'd0;
      d = $urandom;
      issue(k, op != 2 && op != 3, a, 4'($urandom), d, op >= 2, ra);
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (12) step();
  endtask

  initial begin
    int n;
    reset = 1;
    for (int k = 0; k < NI; k++) begin
      wr_valid[k] = 0;
      wr_address[k] = '0;
      wr_byte[k] = '0;
      wr_data[k] = '0;
      rd_req[k] = 0;
      rd_address[k] = '0;
    end
    repeat (3) step();
    reset = 0;
    step();
    for (int k = 0; k < NI; k++) run_tests(k);
    n = 0;
    while ((pend_cnt[0] + pend_cnt[1] + pend_cnt[2]) != 0 && n < 100) begin
      step();
      n++;
    end
    chk("loads_drained", 0, 32'(pend_cnt[0] + pend_cnt[1] + pend_cnt[2]), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
